// File: rtl/regfile_pkg.sv
// Purpose : shared encodings for the multi-port register file (read-source select, clear FSM states).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Read-source select per port; 2'b11 is decoded as GPR.
  localparam logic [1:0] SEL_GPR = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Purpose : bundles the decode-side read ports and writeback-side write port of regfile_mp.
// Latency : n/a (wiring only).
// Backpressure: none; busy/wr_drop report writes discarded during the clear sweep.
// Ports: rd_en/rd_sel/rd_addr -> rd_data (per port, packed), wr_* write port, busy, wr_drop.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0]        rd_en;
  logic [2*NUM_RD-1:0]      rd_sel;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic                     wr_hilo;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        wr_lo;
  logic                     busy;
  logic                     wr_drop;

  // Pipeline side: decode drives reads, writeback drives the write port.
  modport master (
    output rd_en, rd_sel, rd_addr, wr_en, wr_hilo, wr_addr, wr_data, wr_lo,
    input  rd_data, busy, wr_drop
  );

  // Register-file side.
  modport slave (
    input  rd_en, rd_sel, rd_addr, wr_en, wr_hilo, wr_addr, wr_data, wr_lo,
    output rd_data, busy, wr_drop
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Purpose : post-reset sweep that zeroes one register entry per cycle, then parks in RUN.
// Latency : busy stays high for exactly 2**ADDR_W posedges after RST is released.
// Backpressure: busy=1 tells the top level to discard user writes and return 0 on reads.
// Ports: CLK, RST (sync, active-high) in; busy, clr_we, clr_addr out.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = clr_cnt;
    busy    = 1'b0;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        // Hold off the sweep while reset is asserted so a restart begins at entry 0.
        clr_we = ~RST;
        cnt_d  = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Purpose : NUM_RD-read / 1-write GPR file plus HI/LO pair, with optional same-cycle write bypass.
// Latency : reads registered, data visible 1 cycle after rd_en; writes land at the same posedge.
// Backpressure: none; writes during the clear sweep are dropped and flagged on wr_drop next cycle.
// Ports: CLK, RST (sync, active-high); bus (regfile_mp_if.slave) carries read ports, write port, busy, wr_drop.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic         CLK,
  input  logic         RST,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .CLK      (CLK),
    .RST      (RST),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              wr_drop_q;

  // User writes only take effect in RUN and never while reset is asserted.
  logic user_we, gpr_we, hilo_we;
  assign user_we = bus.wr_en & ~busy & ~RST;
  assign gpr_we  = user_we & ~bus.wr_hilo & (bus.wr_addr != '0);
  assign hilo_we = user_we &  bus.wr_hilo;

  // Single array write port shared by the clear sweep and the user (mutually exclusive via busy).
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  assign arr_we    = clr_we | gpr_we;
  assign arr_addr  = clr_we ? clr_addr : bus.wr_addr;
  assign arr_wdata = clr_we ? '0 : bus.wr_data;

  // The array is not reset; the clear sweep zeroes it before any read can see it.
  always_ff @(posedge CLK) begin
    if (arr_we) mem[arr_addr] <= arr_wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_q      <= '0;
      lo_q      <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      if (hilo_we) begin
        hi_q <= bus.wr_data;
        lo_q <= bus.wr_lo;
      end
      wr_drop_q <= busy & bus.wr_en;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [1:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] q;

    assign sel  = bus.rd_sel[2*p +: 2];
    assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      val = '0;
      if (!busy) begin
        case (sel)
          SEL_HI:  val = ((BYPASS != 0) && hilo_we) ? bus.wr_data : hi_q;
          SEL_LO:  val = ((BYPASS != 0) && hilo_we) ? bus.wr_lo   : lo_q;
          default: begin
            // gpr_we already excludes address 0, so r0 stays hard-wired to zero.
            if (addr == '0)
              val = '0;
            else if ((BYPASS != 0) && gpr_we && (addr == bus.wr_addr))
              val = bus.wr_data;
            else
              val = mem[addr];
          end
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (RST)                q <= '0;
      else if (bus.rd_en[p])  q <= val;
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = q;
  end

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;

endmodule
